// File: rtl/clock_pkg.sv
// Shared definitions for the time/date counter: edit-state encoding,
// field limits and calendar helpers.
package clock_pkg;

  localparam logic [2:0] EF_RUN   = 3'd0;
  localparam logic [2:0] EF_YEAR  = 3'd1;
  localparam logic [2:0] EF_MONTH = 3'd2;
  localparam logic [2:0] EF_DAY   = 3'd3;
  localparam logic [2:0] EF_HOUR  = 3'd4;
  localparam logic [2:0] EF_MIN   = 3'd5;

  // State codes equal the edit_field codes so the state register drives the output directly.
  typedef enum logic [2:0] {
    ST_RUN   = EF_RUN,
    ST_YEAR  = EF_YEAR,
    ST_MONTH = EF_MONTH,
    ST_DAY   = EF_DAY,
    ST_HOUR  = EF_HOUR,
    ST_MIN   = EF_MIN
  } state_e;

  localparam logic [5:0]  SEC_MAX   = 6'd59;
  localparam logic [5:0]  MIN_MAX   = 6'd59;
  localparam logic [4:0]  HOUR_MAX  = 5'd23;
  localparam logic [3:0]  MONTH_MAX = 4'd12;
  localparam logic [13:0] YEAR_MAX  = 14'd9999;

  function automatic logic is_leap(input logic [13:0] y);
    return (((y % 14'd4) == 14'd0) && ((y % 14'd100) != 14'd0)) || ((y % 14'd400) == 14'd0);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [13:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return is_leap(y) ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/time_date_counter_if.sv
// Control inputs and time/date outputs of the counter; master drives, slave is the counter.
interface time_date_counter_if;
  logic        clk_1s;
  logic        clk_0_5s;
  logic        btn_mode;
  logic        btn_inc;
  logic [5:0]  sec;
  logic [5:0]  min;
  logic [4:0]  hour;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [13:0] year;
  logic [2:0]  edit_field;
  logic        blink;

  modport master (
    output clk_1s, clk_0_5s, btn_mode, btn_inc,
    input  sec, min, hour, day, month, year, edit_field, blink
  );

  modport slave (
    input  clk_1s, clk_0_5s, btn_mode, btn_inc,
    output sec, min, hour, day, month, year, edit_field, blink
  );
endinterface

// File: rtl/month_length.sv
// Combinational days-in-month lookup for a given month/year.
module month_length
  import clock_pkg::*;
(
  input  logic [3:0]  month,
  input  logic [13:0] year,
  output logic [4:0]  days
);
  assign days = days_in_month(month, year);
endmodule

// File: rtl/time_date_counter.sv
// Calendar clock with seconds-tick carry chain and a button-driven field editor.
module time_date_counter
  import clock_pkg::*;
#(
  parameter int START_YEAR = 2000
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  time_date_counter_if.slave bus
);
  localparam int SYNC_STAGES = 2;

  logic                 s1, s2, hist;
  logic [SYNC_STAGES:0] vld_pipe;
  logic                 b1, b2;
  logic                 tick;
  logic                 blink;
  state_e               state;
  logic [5:0]           sec, min;
  logic [4:0]           hour, day;
  logic [3:0]           month;
  logic [13:0]          year;

  logic [13:0] year_nx;
  logic [3:0]  month_nx;
  logic [3:0]  ml_month;
  logic [13:0] ml_year;
  logic [4:0]  dim;

  // hist only counts as a real sample once vld_pipe has filled, so a clk_1s
  // already high at reset release does not fake a rising edge.
  assign tick = s2 && !hist && vld_pipe[SYNC_STAGES];

  // Lookup follows the value the field is about to take, so an edit clamps day in the same cycle.
  always_comb begin
    year_nx  = (year == YEAR_MAX) ? 14'd0 : year + 14'd1;
    month_nx = (month == MONTH_MAX) ? 4'd1 : month + 4'd1;
    ml_month = month;
    ml_year  = year;
    if (!bus.btn_mode && bus.btn_inc) begin
      if (state == ST_YEAR)  ml_year  = year_nx;
      if (state == ST_MONTH) ml_month = month_nx;
    end
  end

  month_length u_month_length (.month(ml_month), .year(ml_year), .days(dim));

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      hist     <= 1'b0;
      vld_pipe <= '0;
      b1       <= 1'b0;
      b2       <= 1'b0;
      blink    <= 1'b0;
      state    <= ST_RUN;
      sec      <= '0;
      min      <= '0;
      hour     <= '0;
      day      <= 5'd1;
      month    <= 4'd1;
      year     <= 14'(START_YEAR);
    end else begin
      s1       <= bus.clk_1s;
      s2       <= s1;
      hist     <= s2;
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      b1       <= bus.clk_0_5s;
      b2       <= b1;
      blink    <= (state != ST_RUN) && b2;

      case (state)
        ST_RUN: begin
          if (bus.btn_mode) state <= ST_YEAR;
          else if (tick) begin
            if (sec != SEC_MAX) sec <= sec + 6'd1;
            else begin
              sec <= '0;
              if (min != MIN_MAX) min <= min + 6'd1;
              else begin
                min <= '0;
                if (hour != HOUR_MAX) hour <= hour + 5'd1;
                else begin
                  hour <= '0;
                  if (day < dim) day <= day + 5'd1;
                  else begin
                    day   <= 5'd1;
                    month <= month_nx;
                    if (month == MONTH_MAX) year <= year_nx;
                  end
                end
              end
            end
          end
        end
        ST_YEAR: begin
          if (bus.btn_mode) state <= ST_MONTH;
          else if (bus.btn_inc) begin
            year <= year_nx;
            if (day > dim) day <= dim;
          end
        end
        ST_MONTH: begin
          if (bus.btn_mode) state <= ST_DAY;
          else if (bus.btn_inc) begin
            month <= month_nx;
            if (day > dim) day <= dim;
          end
        end
        ST_DAY: begin
          if (bus.btn_mode) state <= ST_HOUR;
          else if (bus.btn_inc) day <= (day >= dim) ? 5'd1 : day + 5'd1;
        end
        ST_HOUR: begin
          if (bus.btn_mode) state <= ST_MIN;
          else if (bus.btn_inc) hour <= (hour == HOUR_MAX) ? 5'd0 : hour + 5'd1;
        end
        ST_MIN: begin
          if (bus.btn_mode) begin
            state <= ST_RUN;
            sec   <= '0;
          end else if (bus.btn_inc) min <= (min == MIN_MAX) ? 6'd0 : min + 6'd1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.sec        = sec;
  assign bus.min        = min;
  assign bus.hour       = hour;
  assign bus.day        = day;
  assign bus.month      = month;
  assign bus.year       = year;
  assign bus.edit_field = state;
  assign bus.blink      = blink;

endmodule
